matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Upstream controller for the 4x4x16-bit matrix multiplier. On a start command it fetches
//  matrix A and matrix B (one 256-bit word each) from a word-addressed memory and loads them
//  through the multiplier's enable/RW/fleg handshake. It then reads the product and writes it
//  back to memory at a third address. It is the only master of the multiplier's input bus.
// PARAMETERS
//  ADDR_W      16      memory word-address width
//  TIMEOUT_CYC 1023    watchdog limit in cycles per multiplier wait state (only with MMSEQ_TIMEOUT_EN)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous active-high reset
//  start      in   1       one-cycle command strobe; ignored while busy=1
//  addr_a     in   ADDR_W  address of matrix A, sampled with start
//  addr_b     in   ADDR_W  address of matrix B, sampled with start
//  addr_c     in   ADDR_W  result address, sampled with start
//  busy       out  1       high from the cycle after an accepted start until done
//  done       out  1       one-cycle pulse when the result write is acknowledged
//  error      out  1       one-cycle pulse with done on watchdog abort (macro only, else tied 0)
//  mem_req    out  1       memory request; held until mem_ack
//  mem_we     out  1       1=write, 0=read; valid with mem_req
//  mem_addr   out  ADDR_W  request address
//  mem_wdata  out  256     write data (result matrix)
//  mem_rdata  in   256     read data, valid when mem_ack=1 on a read
//  mem_ack    in   1       request complete; one outstanding request max
//  mm_data    out  256     to multiplier dataInBus; element [i][j] at bits i*64+16*j +:16
//  mm_enable  out  1       multiplier enable
//  mm_rw      out  1       1=load matrix, 0=read result
//  mm_fleg    in   1       multiplier status flag
//  mm_result  in   256     multiplier dataOut, same packing as mm_data
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy, done, error, mem_req, mem_we, mm_enable,
//    mm_rw = 0; mem_addr, mem_wdata, mm_data = 0; latched addresses and A/B buffers cleared.
//  - All inputs are sampled on posedge clk; all outputs are registered.
//  - FSM:
//    IDLE      start=1 -> latch addr_a/b/c, go to RD_A.
//    RD_A      mem_req=1, we=0, addr=A; on mem_ack, capture mem_rdata into bufA -> RD_B.
//    RD_B      mem_req=1, we=0, addr=B; on mem_ack, capture bufB -> LOAD_A.
//    LOAD_A    mm_enable=1, mm_rw=1, mm_data=bufA; wait for mm_fleg=1 -> LOAD_B.
//    LOAD_B    mm_enable=1, mm_rw=1, mm_data=bufB; wait for mm_fleg=0 -> CALC.
//    CALC      mm_enable=1, mm_rw=1, mm_data=bufB; wait for mm_fleg=1 -> READ.
//    READ      mm_enable=1, mm_rw=0; wait for mm_fleg=0, then capture mm_result on the next
//              posedge into mem_wdata -> WR_C.
//    WR_C      mm_enable=0; mem_req=1, we=1, addr=C; on mem_ack -> DONE.
//    DONE      done=1 for one cycle, busy=0 -> IDLE.
//  - mem_req drops in the cycle after mem_ack. Between requests it is low for at least one cycle.
//  - mem_addr/mem_we/mem_wdata stay stable while mem_req=1.
//  - mm_enable is 0 in IDLE, RD_A, RD_B, WR_C and DONE, so the multiplier sees no stray loads.
//  - start asserted in the same cycle as DONE is ignored. start while busy is dropped silently.
//  - addr_a==addr_b is legal (A squared). addr_c may alias A or B; the write occurs after both reads.
//  - No arithmetic is performed here; data passes bit-exact, 16-bit wrap is the multiplier's.
//  - Latency with zero-wait memory: start -> done = 3 memory cycles + handshake cycles + 1.
//  - Reset mid-operation aborts immediately. A pending memory request is withdrawn with no
//    completion. The multiplier is not reset by this block; the system resets both together.
// CONFIGURATION
//  MMSEQ_TIMEOUT_EN defined:
//    - A counter runs in LOAD_A, LOAD_B, CALC and READ and clears on every state change.
//    - When it reaches TIMEOUT_CYC: mm_enable->0, skip WR_C, pulse done and error together,
//      return to IDLE. No memory write occurs.
//  MMSEQ_TIMEOUT_EN undefined:
//    - No counter; wait states hang until mm_fleg moves; error is tied to 0.
// TESTING
//  1 A=identity@0x10, B=elements 1..16@0x11, start, C=0x12 -> mem[0x12]==B, done pulses once.
//  2 A=all 2, B=all 3 -> every result element 0x0018; three mem_req transactions, the last
//    with we=1 addr=C.
//  3 A=all 0x0100, B=all 0x0100 -> every element 0x0000 (16-bit wrap passed through unchanged).
//  4 mem_ack delayed 5 cycles on each request -> mem_addr/we/wdata stable throughout;
//    start pulses during busy have no effect; exactly one done.
//  5 rst asserted in CALC -> same cycle: mm_enable=0, mem_req=0, busy=0; a new start runs cleanly.
//  6 (MMSEQ_TIMEOUT_EN, TIMEOUT_CYC=15) mm_fleg stuck 0 in LOAD_A -> done&error pulse
//    15 cycles after entering LOAD_A; no write to C.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// Bus bundle between matmul_sequencer and its environment: command port, memory port
// and the multiplier's enable/RW/fleg port.
interface matmul_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_c;
  logic              busy;
  logic              done;
  logic              error;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [255:0]      mem_wdata;
  logic [255:0]      mem_rdata;
  logic              mem_ack;

  logic [255:0]      mm_data;
  logic              mm_enable;
  logic              mm_rw;
  logic              mm_fleg;
  logic [255:0]      mm_result;

  modport master (
    input  start, addr_a, addr_b, addr_c, mem_rdata, mem_ack, mm_fleg, mm_result,
    output busy, done, error, mem_req, mem_we, mem_addr, mem_wdata, mm_data, mm_enable, mm_rw
  );

  modport slave (
    output start, addr_a, addr_b, addr_c, mem_rdata, mem_ack, mm_fleg, mm_result,
    input  busy, done, error, mem_req, mem_we, mem_addr, mem_wdata, mm_data, mm_enable, mm_rw
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Fetches A and B from memory, drives them through the 4x4 multiplier handshake and writes
// the product back. Define MMSEQ_TIMEOUT_EN to add a watchdog on the multiplier wait states.
module matmul_sequencer #(
  parameter int ADDR_W = 16
`ifdef MMSEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1023
`endif
) (
  input  logic clk,
  input  logic rst,
  matmul_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RD_A, RD_B, LOAD_A, LOAD_B, CALC, READ, WR_C, DONE
  } state_t;

  state_t stateReg, stateNext;

  logic [ADDR_W-1:0] addrAReg, addrBReg, addrCReg;
  logic [255:0]      bufAReg, bufBReg;

  logic              busyReg, doneReg, errorReg;
  logic              memReqReg, memWeReg;
  logic [ADDR_W-1:0] memAddrReg;
  logic [255:0]      memWdataReg;
  logic              mmEnableReg, mmRwReg;
  logic [255:0]      mmDataReg;

  logic              busyNext, doneNext, errorNext;
  logic              memReqNext, memWeNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic              mmEnableNext, mmRwNext;
  logic [255:0]      mmDataNext;

  // An acknowledge only counts against a request we are actually holding.
  logic memAckd;
  assign memAckd = memReqReg && bus.mem_ack;

  logic timeoutHit;
`ifdef MMSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timerReg;
  logic          waitState;

  assign waitState  = stateReg inside {LOAD_A, LOAD_B, CALC, READ};
  assign timeoutHit = waitState && (timerReg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timerReg <= '0;
    else if (!waitState || stateNext != stateReg)
      timerReg <= '0;
    else
      timerReg <= timerReg + 1'b1;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stateReg <= IDLE;
    else
      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (bus.start)    stateNext = RD_A;
      RD_A:    if (memAckd)      stateNext = RD_B;
      RD_B:    if (memAckd)      stateNext = LOAD_A;
      LOAD_A:  if (bus.mm_fleg)  stateNext = LOAD_B;
      LOAD_B:  if (!bus.mm_fleg) stateNext = CALC;
      CALC:    if (bus.mm_fleg)  stateNext = READ;
      READ:    if (!bus.mm_fleg) stateNext = WR_C;
      WR_C:    if (memAckd)      stateNext = DONE;
      DONE:                      stateNext = IDLE;
      default:                   stateNext = IDLE;
    endcase
    if (timeoutHit)
      stateNext = DONE;
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    busyNext     = !(stateNext inside {IDLE, DONE});
    doneNext     = (stateNext == DONE);
    errorNext    = timeoutHit;
    mmEnableNext = stateNext inside {LOAD_A, LOAD_B, CALC, READ};
    mmRwNext     = stateNext inside {LOAD_A, LOAD_B, CALC};
    memWeNext    = (stateNext == WR_C);
    // Dropping req on the ack edge guarantees an idle cycle before the next request.
    memReqNext   = (stateNext inside {RD_A, RD_B, WR_C}) && !memAckd;
    mmDataNext   = '0;
    memAddrNext  = memAddrReg;
    case (stateNext)
      RD_A:         memAddrNext = (stateReg == IDLE) ? bus.addr_a : addrAReg;
      RD_B:         memAddrNext = addrBReg;
      WR_C:         memAddrNext = addrCReg;
      LOAD_A:       mmDataNext  = bufAReg;
      LOAD_B, CALC: mmDataNext  = bufBReg;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrAReg    <= '0;
      addrBReg    <= '0;
      addrCReg    <= '0;
      bufAReg     <= '0;
      bufBReg     <= '0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      errorReg    <= 1'b0;
      memReqReg   <= 1'b0;
      memWeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      mmEnableReg <= 1'b0;
      mmRwReg     <= 1'b0;
      mmDataReg   <= '0;
    end else begin
      busyReg     <= busyNext;
      doneReg     <= doneNext;
      errorReg    <= errorNext;
      memReqReg   <= memReqNext;
      memWeReg    <= memWeNext;
      memAddrReg  <= memAddrNext;
      mmEnableReg <= mmEnableNext;
      mmRwReg     <= mmRwNext;
      mmDataReg   <= mmDataNext;
      if (stateReg == IDLE && bus.start) begin
        addrAReg <= bus.addr_a;
        addrBReg <= bus.addr_b;
        addrCReg <= bus.addr_c;
      end
      if (stateReg == RD_A && memAckd)
        bufAReg <= bus.mem_rdata;
      if (stateReg == RD_B && memAckd)
        bufBReg <= bus.mem_rdata;
      if (stateReg == READ && stateNext == WR_C)
        memWdataReg <= bus.mm_result;
    end
  end

  assign bus.busy      = busyReg;
  assign bus.done      = doneReg;
  assign bus.error     = errorReg;
  assign bus.mem_req   = memReqReg;
  assign bus.mem_we    = memWeReg;
  assign bus.mem_addr  = memAddrReg;
  assign bus.mem_wdata = memWdataReg;
  assign bus.mm_enable = mmEnableReg;
  assign bus.mm_rw     = mmRwReg;
  assign bus.mm_data   = mmDataReg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: behavioural memory and multiplier responders,
// hand-computed result matrices, reset abort and (with MMSEQ_TIMEOUT_EN) watchdog abort.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_sequencer_if #(.ADDR_W(16)) bus ();

  matmul_sequencer #(
    .ADDR_W(16)
`ifdef MMSEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(15)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vecCount = 0;
  int missCount = 0;

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] splat(input logic [15:0] v);
    return {16{v}};
  endfunction

  // Reference multiplier used only by the responder model below.
  function automatic logic [255:0] matProduct(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [15:0]  acc;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc + 16'(a[i*64+16*k +: 16] * b[k*64+16*j +: 16]);
        r[i*64+16*j +: 16] = acc;
      end
    return r;
  endfunction

  // Memory responder
  logic [255:0] mem [0:255];
  int           memDelay = 1;
  int           memWait = 0;
  int           reqCount = 0;
  int           wrCount = 0;
  logic         prevReq = 1'b0;
  logic         lastWe = 1'b0;
  logic [15:0]  lastAddr = '0;
  logic [255:0] lastWdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      memWait       = 0;
      prevReq       = 1'b0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      checkVal("req gap", 256'(bus.mem_req), 256'(0));
      prevReq = bus.mem_req;
    end else if (bus.mem_req) begin
      if (!prevReq) begin
        reqCount++;
        lastWe    = bus.mem_we;
        lastAddr  = bus.mem_addr;
        lastWdata = bus.mem_wdata;
      end else begin
        checkVal("addr stable", 256'(bus.mem_addr), 256'(lastAddr));
        checkVal("we stable", 256'(bus.mem_we), 256'(lastWe));
        checkVal("wdata stable", bus.mem_wdata, lastWdata);
      end
      prevReq = 1'b1;
      memWait++;
      if (memWait >= memDelay) begin
        memWait     = 0;
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem[bus.mem_addr[7:0]] = bus.mem_wdata;
          wrCount++;
        end else begin
          bus.mem_rdata = mem[bus.mem_addr[7:0]];
        end
        $display("mem %s addr=%h data=%h", bus.mem_we ? "wr" : "rd", bus.mem_addr,
                 bus.mem_we ? bus.mem_wdata : bus.mem_rdata);
      end
    end else begin
      prevReq = 1'b0;
    end
  end

  // Multiplier responder: each handshake phase answers two cycles after enable is seen.
  int           mmPhase = 0;
  int           mmCnt = 0;
  logic         mmStuck = 1'b0;
  logic [255:0] mA, mB;

  always @(negedge clk) begin
    if (rst) begin
      mmPhase       = 0;
      mmCnt         = 0;
      bus.mm_fleg   = 1'b0;
      bus.mm_result = '0;
    end else if (bus.mm_enable && !mmStuck) begin
      mmCnt++;
      if (mmCnt >= 2) begin
        mmCnt = 0;
        case (mmPhase)
          0: if (bus.mm_rw) begin mA = bus.mm_data; bus.mm_fleg = 1'b1; mmPhase = 1; end
          1: if (bus.mm_rw) begin mB = bus.mm_data; bus.mm_fleg = 1'b0; mmPhase = 2; end
          2: begin bus.mm_result = matProduct(mA, mB); bus.mm_fleg = 1'b1; mmPhase = 3; end
          3: if (!bus.mm_rw) begin bus.mm_fleg = 1'b0; mmPhase = 0; end
          default: mmPhase = 0;
        endcase
      end
    end
  end

  int doneCount = 0;
  int errCount = 0;
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      doneCount++;
      if (bus.error) errCount++;
    end
  end

  task automatic pulseStart(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    bus.addr_a = a;
    bus.addr_b = b;
    bus.addr_c = c;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input bit noisyStart);
    int doneBefore;
    int n;
    doneBefore = doneCount;
    pulseStart(a, b, c);
    n = 0;
    while (doneCount == doneBefore && n < 3000) begin
      @(negedge clk);
      n++;
      if (noisyStart && bus.busy && (n % 7 == 0)) begin
        bus.addr_a = 16'h0077;
        bus.addr_b = 16'h0078;
        bus.addr_c = 16'h0079;
        bus.start  = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (doneCount == doneBefore)
      checkVal({tag, " done timeout"}, 256'(0), 256'(1));
    repeat (4) @(negedge clk);
    checkVal({tag, " done once"}, 256'(doneCount - doneBefore), 256'(1));
    checkVal({tag, " idle busy"}, 256'(bus.busy), 256'(0));
    $display("op %s a=%h b=%h c=%h cycles=%0d", tag, a, b, c, n);
  endtask

  logic [255:0] ident, seqM, colSum;
  int reqBefore, wrBefore, n;

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.addr_a = '0;
    bus.addr_b = '0;
    bus.addr_c = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    ident = '0;
    seqM  = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        seqM[i*64+16*j +: 16] = 16'(i*4 + j + 1);
        if (i == j) ident[i*64+16*j +: 16] = 16'h0001;
      end
    colSum = {4{16'h0028, 16'h0024, 16'h0020, 16'h001C}};

    #2;
    checkVal("rst busy", 256'(bus.busy), 256'(0));
    checkVal("rst done", 256'(bus.done), 256'(0));
    checkVal("rst error", 256'(bus.error), 256'(0));
    checkVal("rst ctl", 256'({bus.mem_req, bus.mem_we, bus.mm_enable, bus.mm_rw}), 256'(0));
    checkVal("rst addr", 256'(bus.mem_addr), 256'(0));
    checkVal("rst wdata", bus.mem_wdata, '0);
    checkVal("rst mmdata", bus.mm_data, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: identity * B = B
    mem[8'h10] = ident;
    mem[8'h11] = seqM;
    runOp("ident", 16'h0010, 16'h0011, 16'h0012, 1'b0);
    checkVal("ident result", mem[8'h12], seqM);

    // 2: all-2 * all-3 -> 0x18, three requests with the write last
    mem[8'h20] = splat(16'h0002);
    mem[8'h21] = splat(16'h0003);
    reqBefore = reqCount;
    runOp("twothree", 16'h0020, 16'h0021, 16'h0022, 1'b0);
    checkVal("twothree result", mem[8'h22], splat(16'h0018));
    checkVal("twothree reqs", 256'(reqCount - reqBefore), 256'(3));
    checkVal("twothree last we", 256'(lastWe), 256'(1));
    checkVal("twothree last addr", 256'(lastAddr), 256'(16'h0022));

    // 3: A squared with 16-bit wrap to zero
    mem[8'h30] = splat(16'h0100);
    mem[8'h31] = splat(16'hDEAD);
    runOp("wrap", 16'h0030, 16'h0030, 16'h0031, 1'b0);
    checkVal("wrap result", mem[8'h31], '0);

    // 4: slow memory, stray starts while busy, C aliases A
    memDelay   = 5;
    mem[8'h40] = splat(16'h0001);
    mem[8'h41] = seqM;
    mem[8'h79] = splat(16'hBEEF);
    wrBefore   = wrCount;
    runOp("slow", 16'h0040, 16'h0041, 16'h0040, 1'b1);
    checkVal("slow result", mem[8'h40], colSum);
    checkVal("slow writes", 256'(wrCount - wrBefore), 256'(1));
    checkVal("slow stray c", mem[8'h79], splat(16'hBEEF));
    memDelay = 1;

    // 5: reset during CALC aborts, then a fresh run succeeds
    mem[8'h60] = splat(16'h5A5A);
    pulseStart(16'h0020, 16'h0021, 16'h0060);
    n = 0;
    while (mmPhase != 2 && n < 500) begin @(negedge clk); n++; end
    if (mmPhase != 2) checkVal("calc reach", 256'(mmPhase), 256'(2));
    @(posedge clk);
    #1;
    checkVal("calc enable", 256'(bus.mm_enable), 256'(1));
    rst = 1'b1;
    #1;
    checkVal("abort enable", 256'(bus.mm_enable), 256'(0));
    checkVal("abort req", 256'(bus.mem_req), 256'(0));
    checkVal("abort busy", 256'(bus.busy), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runOp("rerun", 16'h0010, 16'h0011, 16'h0050, 1'b0);
    checkVal("rerun result", mem[8'h50], seqM);
    checkVal("abort no write", mem[8'h60], splat(16'h5A5A));
    checkVal("no error", 256'(errCount), 256'(0));

`ifdef MMSEQ_TIMEOUT_EN
    // 6: multiplier never answers, watchdog fires 15 cycles into LOAD_A
    begin
      int enterAt, doneAt;
      mmStuck    = 1'b1;
      mem[8'h70] = splat(16'h1234);
      wrBefore   = wrCount;
      enterAt    = -1;
      doneAt     = -1;
      pulseStart(16'h0010, 16'h0011, 16'h0070);
      for (int c = 0; c < 200 && doneAt < 0; c++) begin
        if (enterAt < 0 && bus.mm_enable) enterAt = c;
        if (bus.done) begin
          doneAt = c;
          checkVal("wdog error", 256'(bus.error), 256'(1));
        end
        @(negedge clk);
      end
      checkVal("wdog latency", 256'(doneAt - enterAt), 256'(15));
      checkVal("wdog no write", 256'(wrCount - wrBefore), 256'(0));
      checkVal("wdog mem c", mem[8'h70], splat(16'h1234));
      mmStuck = 1'b0;
      repeat (3) @(negedge clk);
      checkVal("wdog idle", 256'({bus.busy, bus.mm_enable}), 256'(0));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
